gift_input_loader: RTL
======================

Name: gift_input_loader

Overview:
- Upstream feeder for the GIFT-128 encryption control/datapath (40-round iterative core).
- Accepts 32-bit words over a valid/ready stream and assembles 128-bit key and plaintext frames.
- Issues the single-cycle key-write and data-write strobes that load the key schedule and round registers, only while the core reports idle.

Parameters:
- WORD_W, 32, stream word width; fixed, other values unsupported.
- BLOCK_W, 128, key/plaintext width; WORDS = BLOCK_W/WORD_W = 4.

Ports:
- inClk  in  1  clock; all logic on rising edge.
- inRst  in  1  synchronous active-high reset.
- inWord  in  32  stream word.
- inWordValid  in  1  word present.
- inWordIsKey  in  1  1 = key word, 0 = plaintext word.
- outWordReady  out  1  word accepted when inWordValid & outWordReady.
- inCoreBusy  in  1  core busy flag (high during rounds 1..40).
- outKey  out  128  key holding register to the key schedule.
- outData  out  128  plaintext holding register to the round register.
- outExtKeyWr  out  1  one-cycle key load strobe.
- outExtDataWr  out  1  one-cycle plaintext load strobe; starts encryption.
- outLoaderBusy  out  1  partial frame, pending frame or FSM not IDLE.
- outProtoErr  out  1  sticky frame-type error.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything, including mid-frame or mid-ISSUE):
  - All outputs, holding registers, word count, frame type, pending flags and FSM state go to 0 / IDLE.
  - outWordReady = 1 in the first cycle after reset.
  - A strobe asserted in the reset cycle is low in the next cycle.
- Framing:
  - Word count cnt is 2 bits. The first word of a frame latches the frame type from inWordIsKey.
  - Words fill the staging register MSB first: word0 -> [127:96], word3 -> [31:0].
  - cnt wraps from 3 to 0 when the frame completes.
- Frame completion (4th word accepted in cycle t):
  - At the end of t, staging plus word3 is copied into outKey or outData.
  - keyPend or dataPend is set at the same edge.
  - The other holding register is untouched.
- Type mismatch (cnt != 0 and inWordIsKey differs from the latched type, word accepted):
  - The partial frame is discarded and the accepted word becomes word0 of a new frame of the new type (cnt = 1).
  - outProtoErr is set; it clears only on reset.
- Ready:
  - outWordReady = 0 only when cnt == 3 and the pending flag of the latched type is set; otherwise 1.
  - A holding register is therefore never overwritten while its pending flag is set or during ISSUE.
  - outWordReady is registered-state only; it must not depend combinationally on inWordValid.
- FSM states: IDLE, ISSUE, GUARD.
  - IDLE -> ISSUE when (keyPend | dataPend) & !inCoreBusy. Registered strobes in ISSUE: outExtKeyWr = keyPend, outExtDataWr = dataPend, both sampled at the transition edge.
  - ISSUE -> GUARD after one cycle. Issued pending flags clear at the end of ISSUE. A flag set at that same edge by frame completion is impossible, because ready blocks it.
  - GUARD -> IDLE after one cycle. This covers the one-cycle lag before the core raises busy.
- Simultaneous pending: key and data strobes are asserted in the same ISSUE cycle, so the key loads together with the block.
- Key-only or data-only issue is legal; a data-only issue uses the previously loaded key.
- Latency: 4th word accepted in cycle t with core idle -> strobe high in cycle t+2, exactly one cycle wide.
- Busy wait: inCoreBusy falls in cycle b with a flag pending -> strobe in cycle b+1.
- outLoaderBusy = (cnt != 0) | keyPend | dataPend | (state != IDLE), registered-state derived.
- No back-to-back strobes; minimum strobe spacing is 3 cycles.

Test Plan:
- Reset:
  - Stimulus: hold inRst 2 cycles with random inputs.
  - Required: all outputs 0 except outWordReady = 1; outLoaderBusy = 0.
- Key then data, core idle:
  - Stimulus: key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, then data words 0xFFEEDDCC, 0xBBAA9988, 0x77665544, 0x33221100.
  - Required: outKey = 0x000102030405060708090A0B0C0D0E0F, outExtKeyWr high exactly 1 cycle at t+2; outData = 0xFFEEDDCCBBAA99887766554433221100, outExtDataWr 1 cycle at t+2.
- Joint issue:
  - Stimulus: inCoreBusy = 1; send a full key frame then a full data frame; drop busy in cycle b.
  - Required: outExtKeyWr and outExtDataWr both high in cycle b+1 only.
- Backpressure:
  - Stimulus: inCoreBusy = 1 for 41 cycles; send 2 data frames back-to-back.
  - Required: outWordReady = 0 on the 2nd frame's 4th word until the first frame's ISSUE completes; the 2nd frame issues only after busy rises and falls again.
- Type error:
  - Stimulus: 2 key words, then 4 data words.
  - Required: outProtoErr = 1 from the cycle after the first data word; no key strobe; data strobe for the 4-word data frame; outProtoErr stays 1.
- Reset mid-operation:
  - Stimulus: assert inRst in the ISSUE cycle, and separately with cnt = 2.
  - Required: strobes low next cycle, cnt = 0, no strobe afterwards without a new frame.

Source files
------------

// File: rtl/gift_input_loader.sv
// gift_input_loader: assembles 32-bit stream words into 128-bit key/plaintext frames
// and issues one-cycle load strobes to the GIFT-128 core while it is idle.
module gift_input_loader #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128
) (
    input  logic               inClk,
    input  logic               inRst,
    input  logic [WORD_W-1:0]  inWord,
    input  logic               inWordValid,
    input  logic               inWordIsKey,
    output logic               outWordReady,
    input  logic               inCoreBusy,
    output logic [BLOCK_W-1:0] outKey,
    output logic [BLOCK_W-1:0] outData,
    output logic               outExtKeyWr,
    output logic               outExtDataWr,
    output logic               outLoaderBusy,
    output logic               outProtoErr
);
    localparam int WORDS = BLOCK_W / WORD_W;

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

    state_t                     state;
    logic [1:0]                 cnt;
    logic                       frameKey;
    logic                       keyPend;
    logic                       dataPend;
    logic [BLOCK_W-WORD_W-1:0]  stage;
    logic                       accept;
    logic                       mismatch;
    logic                       first;
    logic                       done;
    logic [1:0]                 slot;

    always_comb begin
        outWordReady  = !((cnt == 2'd3) && (frameKey ? keyPend : dataPend));
        outLoaderBusy = (cnt != 2'd0) || keyPend || dataPend || (state != IDLE);
        accept        = inWordValid && outWordReady;
        mismatch      = (cnt != 2'd0) && (inWordIsKey != frameKey);
        first         = (cnt == 2'd0) || mismatch;
        done          = accept && !first && (cnt == 2'd3);
        slot          = first ? 2'd0 : cnt;
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            frameKey     <= 1'b0;
            keyPend      <= 1'b0;
            dataPend     <= 1'b0;
            stage        <= '0;
            outKey       <= '0;
            outData      <= '0;
            outExtKeyWr  <= 1'b0;
            outExtDataWr <= 1'b0;
            outProtoErr  <= 1'b0;
        end else begin
            if (accept) begin
                if (first)
                    frameKey <= inWordIsKey;
                if (mismatch)
                    outProtoErr <= 1'b1;
                cnt <= first ? 2'd1 : cnt + 2'd1;
                // words 0..2 land MSB first; word 3 goes straight to the holding register
                if (!done)
                    stage[(WORDS-2-int'(slot))*WORD_W +: WORD_W] <= inWord;
                if (done && frameKey)
                    outKey <= {stage, inWord};
                if (done && !frameKey)
                    outData <= {stage, inWord};
            end
            keyPend  <= (keyPend && !(state == ISSUE && outExtKeyWr)) || (done && frameKey);
            dataPend <= (dataPend && !(state == ISSUE && outExtDataWr)) || (done && !frameKey);
            case (state)
                IDLE: begin
                    if ((keyPend || dataPend) && !inCoreBusy) begin
                        state        <= ISSUE;
                        outExtKeyWr  <= keyPend;
                        outExtDataWr <= dataPend;
                    end
                end
                ISSUE: begin
                    state        <= GUARD;
                    outExtKeyWr  <= 1'b0;
                    outExtDataWr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
